// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// latency counter width and data word width.
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store port between the EX/MEM register (master) and the
// data-memory responder (slave).
interface dmem_responder_if;

  logic                             req_i;
  logic                             we_i;
  logic [dmem_pkg::DMEM_WORD_W-1:0] addr_i;
  logic [dmem_pkg::DMEM_WORD_W-1:0] wdata_i;
  logic [dmem_pkg::DMEM_WORD_W-1:0] rdata_o;
  logic                             ack_o;
  logic                             stall_o;
  logic                             err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o, stall_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o, stall_o, err_o
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read data registered every edge, no reset
// so the contents survive a pipeline reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic [DMEM_WORD_W-1:0] wdata_i,
  output logic [DMEM_WORD_W-1:0] rdata_o
);

  logic [DMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [DMEM_WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word access per request, LATENCY wait
// cycles, one-cycle ack. Define DMEM_ALIGN_CHECK_EN to flag/suppress misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_responder_if.slave bus
);

  localparam int               IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DMEM_WORD_W-1:0] wdata_q, wdata_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   ld_q, ld_d;
  logic                   ld_bad_q, ld_bad_d;
  logic [DMEM_WORD_W-1:0] hold_q, hold_d;
  logic [DMEM_WORD_W-1:0] arr_rdata;
  logic [DMEM_WORD_W-1:0] rdata;
  logic                   accept;
  logic                   access;
  logic                   misaligned;
  logic                   mem_we;
  logic                   unused_addr;

  assign accept = (state_q == ST_IDLE) && bus.req_i;
  assign access = (state_q == ST_WAIT) && (cnt_q == '0);
  assign mem_we = access && we_q && !misaligned;

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lsb_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lsb_q <= 2'b00;
    end else if (accept) begin
      lsb_q <= bus.addr_i[1:0];
    end
  end

  assign misaligned  = |lsb_q;
  assign unused_addr = &{1'b0, bus.addr_i[DMEM_WORD_W-1:IDX_W+2]};
`else
  assign misaligned  = 1'b0;
  assign unused_addr = &{1'b0, bus.addr_i[DMEM_WORD_W-1:IDX_W+2], bus.addr_i[1:0]};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    ld_d     = 1'b0;
    ld_bad_d = 1'b0;
    hold_d   = rdata;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          idx_d   = bus.addr_i[IDX_W+1:2];
          wdata_d = bus.wdata_i;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          ack_d    = 1'b1;
          err_d    = misaligned;
          ld_d     = !we_q;
          ld_bad_d = !we_q && misaligned;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      ld_q     <= 1'b0;
      ld_bad_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      ld_q     <= ld_d;
      ld_bad_q <= ld_bad_d;
      hold_q   <= hold_d;
    end
  end

  // RAM output is only meaningful in the ack cycle of a load; otherwise show the held word.
  assign rdata = ld_q ? (ld_bad_q ? '0 : arr_rdata) : hold_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  assign bus.rdata_o = rdata;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.stall_o = bus.req_i & ~ack_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the CPU's MEM-stage load/store port. It accepts one word request at a time, holds the pipeline through `stall_o` for a configurable access latency, then completes the read or write. It returns read data with a single-cycle `ack_o` pulse. It sits between the EX/MEM pipeline register (initiator side) and a private word-addressed storage array.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, default 4: number of wait cycles per access; integer, 1..15.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `req_i`  in  1  access request; the initiator holds it and all request fields stable until `ack_o`.
- `we_i`  in  1  1 = store, 0 = load.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data.
- `rdata_o`  out  32  load data; valid while `ack_o` = 1.
- `ack_o`  out  1  one-cycle completion pulse.
- `stall_o`  out  1  pipeline freeze, combinational: `req_i & ~ack_o`.
- `err_o`  out  1  misaligned-access flag, valid with `ack_o` (see Configuration).

## Operation
- States:
  - IDLE: `req_i` = 1 → latch `we_i`, `addr_i`, `wdata_i`; load counter with `LATENCY-1`; go to WAIT.
  - WAIT: if counter = 0 → perform the access and go to RESP; otherwise decrement the counter.
  - RESP: drive `ack_o` = 1; return to IDLE unconditionally.
- Access is performed on the WAIT→RESP edge.
  - Store writes the latched `wdata_i` into `mem[index]`.
  - Load registers `mem[index]` into `rdata_o`.
- Word index = latched `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses alias and wrap modulo `DEPTH_WORDS*4`.
- `rdata_o` holds its value until the next load completes. A store leaves `rdata_o` unchanged.
- Requests arriving in WAIT or RESP are not new transactions. A new request is sampled only in IDLE, i.e. no earlier than the cycle after `ack_o`.
- If `req_i` drops mid-transaction (protocol violation), the latched transaction still completes and `ack_o` still pulses.
- Storage is not reset. Contents survive `rst_i`.

## Timing
- Reset values: state IDLE, counter 0, `ack_o` 0, `rdata_o` 0, `err_o` 0. `stall_o` follows `req_i` during reset because `ack_o` = 0.
- Request first high in IDLE at cycle n → `ack_o` high in cycle n+1+`LATENCY`, for exactly one cycle.
- `stall_o` is high from cycle n through n+`LATENCY` and low in the ack cycle.
- Back-to-back throughput: one access per `LATENCY`+2 cycles.
- Reset asserted mid-WAIT: an uncompleted store is discarded and memory is not modified. After release, state is IDLE and no `ack_o` appears for the aborted request.
- Reset asserted in RESP: `ack_o` drops immediately (asynchronous).

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - If latched `addr[1:0]` ≠ 0, the access is suppressed: no write, and `rdata_o` is loaded with 0.
  - `err_o` = 1 in the ack cycle; `err_o` is 0 for aligned accesses.
  - Latency is unchanged.
- Not defined:
  - `addr[1:0]` is ignored and the access proceeds on the word index.
  - `err_o` is tied to 0.

## Structure
- Shared package `dmem_pkg`:
  - state encoding (IDLE=0, WAIT=1, RESP=2);
  - counter width constant (4 bits);
  - `DMEM_WORD_W` = 32.
- Sub-module `dmem_array`: single-port synchronous RAM. Ports: clock, write enable, index, write data, read data. Read data is registered on the access edge; there is no reset on the array.
- The top level holds the FSM, latency counter, request latch, output registers, and the alignment check.

## Test plan
- Reset, then store `addr` 0x10, `wdata` 0xDEADBEEF, `LATENCY`=4 → `stall_o` high 5 cycles; `ack_o` in cycle n+5; then load 0x10 → `rdata_o` = 0xDEADBEEF with `ack_o`.
- Load from index 3, then store 0x12345678 to 0x400+0xC (aliases index 3 at depth 256), then load 0xC → returns 0x12345678 (wrap-around).
- `LATENCY`=1 back-to-back: store 0x8 = 0x1; hold `req_i` for a load of 0x8 → acks 3 cycles apart; the load returns 0x1 (read-after-write).
- Assert `rst_i` low in the second WAIT cycle of a store of 0xAAAA5555 to 0x20, release, then load 0x20 → returns the prior contents; no stray `ack_o`.
- With `DMEM_ALIGN_CHECK_EN`: store to 0x22 → `err_o`=1, `ack_o`=1; a load of 0x20 shows memory unchanged. Without the macro, the same store writes index 8 and `err_o`=0.
- Drop `req_i` one cycle after acceptance of a load → `ack_o` still pulses at n+1+`LATENCY`; `stall_o` is 0 while `req_i` is 0.
